// File: rtl/slt_seq_par_if.sv
// Handshake and operand/result bundle for the chunked compare unit.
//   in_valid/in_ready   : operand handshake (producer -> unit)
//   op, r2, r3          : operation select, minuend, subtrahend
//   out_valid/out_ready : result handshake (unit -> consumer)
//   r1, lt_s, lt_u, eq  : selected 0/1 result and the three raw flags
// master = the datapath driving operands and taking results; slave = the unit.
interface slt_seq_par_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] r2;
  logic [N-1:0] r3;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] r1;
  logic         lt_s;
  logic         lt_u;
  logic         eq;

  modport master (
    output in_valid, op, r2, r3, out_ready,
    input  in_ready, out_valid, r1, lt_s, lt_u, eq
  );

  modport slave (
    input  in_valid, op, r2, r3, out_ready,
    output in_ready, out_valid, r1, lt_s, lt_u, eq
  );
endinterface

// File: rtl/slt_seq_par.sv
// Multi-cycle compare unit. Computes r2 - r3 in W-bit chunks, LSB chunk
// first, one chunk per clock, carrying the borrow (as a subtract carry) and a
// running all-zero flag. On the last chunk it registers signed-less-than,
// unsigned-less-than and equality, and drives r1 according to op:
//   00 SLT, 01 SLTU, 10 SEQ, 11 SNE (r1 is 0/1 zero-extended).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slt_seq_par_if slave modport (handshakes, operands, results)
// Latency: accept on edge 0, out_valid high after edge N/W.
module slt_seq_par #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  slt_seq_par_if.slave  bus
);

  localparam int NCH = N / W;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SNE  = 2'b11;

  generate
    if ((W < 1) || ((N % W) != 0)) begin : g_bad_width
      $error("slt_seq_par: N must be a positive integer multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic [N-1:0]  r1_q, r1_d;
  logic          lt_s_q, lt_s_d;
  logic          lt_u_q, lt_u_d;
  logic          eq_q, eq_d;
  logic          out_valid_q, out_valid_d;

  // Current chunk of each captured operand and its subtract result.
  logic [W-1:0]  a_k_s;
  logic [W-1:0]  b_k_s;
  logic [W:0]    sum_s;
  logic          last_s;
  logic          ovf_s;
  logic          lt_s_s;
  logic          lt_u_s;
  logic          eq_s;
  logic          sel_s;

  assign a_k_s  = a_q[W*int'(cnt_q) +: W];
  assign b_k_s  = b_q[W*int'(cnt_q) +: W];
  // r2 + ~r3 + carry; bit W is the chunk carry-out (1 = no borrow).
  assign sum_s  = {1'b0, a_k_s} + {1'b0, ~b_k_s} + {{W{1'b0}}, carry_q};
  assign last_s = (cnt_q == CW'(NCH - 1));
  // Signed overflow only when operand signs differ and the result sign
  // disagrees with the minuend.
  assign ovf_s  = (a_k_s[W-1] ^ b_k_s[W-1]) & (sum_s[W-1] ^ a_k_s[W-1]);
  assign lt_s_s = sum_s[W-1] ^ ovf_s;
  assign lt_u_s = ~sum_s[W];
  assign eq_s   = zero_q & (sum_s[W-1:0] == {W{1'b0}});

  // Result select from the captured op.
  always_comb begin
    sel_s = 1'b0;
    case (op_q)
      OP_SLT:  sel_s = lt_s_s;
      OP_SLTU: sel_s = lt_u_s;
      OP_SEQ:  sel_s = eq_s;
      OP_SNE:  sel_s = ~eq_s;
      default: sel_s = 1'b0;
    endcase
  end

  // State and datapath registers; reset discards any partial computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      op_q        <= 2'b00;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      r1_q        <= {N{1'b0}};
      lt_s_q      <= 1'b0;
      lt_u_q      <= 1'b0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      r1_q        <= r1_d;
      lt_s_q      <= lt_s_d;
      lt_u_q      <= lt_u_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    r1_d        = r1_q;
    lt_s_d      = lt_s_q;
    lt_u_d      = lt_u_q;
    eq_d        = eq_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.r2;
          b_d     = bus.r3;
          op_d    = bus.op;
          carry_d = 1'b1;
          zero_d  = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        carry_d = sum_s[W];
        zero_d  = zero_q & (sum_s[W-1:0] == {W{1'b0}});
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          lt_s_d      = lt_s_s;
          lt_u_d      = lt_u_s;
          eq_d        = eq_s;
          r1_d        = {{(N-1){1'b0}}, sel_s};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.r1        = r1_q;
  assign bus.lt_s      = lt_s_q;
  assign bus.lt_u      = lt_u_q;
  assign bus.eq        = eq_q;

endmodule

// File: tb/tb_slt_seq_par.sv
// Directed bench for slt_seq_par: one instance with N=32/W=8 and one with
// N=32/W=32, hand-computed expected results for each vector.
module tb_slt_seq_par;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  slt_seq_par_if #(.N(32)) bif   ();
  slt_seq_par_if #(.N(32)) bif32 ();

  slt_seq_par #(.N(32), .W(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bif));
  slt_seq_par #(.N(32), .W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bif32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
    bif.op       = o;
    bif.r2       = a;
    bif.r3       = b;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bif.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic finish_op();
    bif.out_ready = 1'b1;
    step();
    bif.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_r1, input logic exp_lts,
                        input logic exp_ltu, input logic exp_eq);
    int cyc;
    check_value({tag, ".in_ready"}, 32'(bif.in_ready), 32'd1);
    start_op(o, a, b);
    // Captured copies must be used, so scribble on the live operands.
    bif.r2 = ~a;
    bif.r3 = a ^ 32'h5A5A_A5A5;
    wait_done(cyc);
    check_value({tag, ".latency"}, 32'(cyc), 32'd4);
    check_value({tag, ".r1"},   bif.r1,          {31'd0, exp_r1});
    check_value({tag, ".lt_s"}, 32'(bif.lt_s),   32'(exp_lts));
    check_value({tag, ".lt_u"}, 32'(bif.lt_u),   32'(exp_ltu));
    check_value({tag, ".eq"},   32'(bif.eq),     32'(exp_eq));
    finish_op();
    check_value({tag, ".out_valid_low"}, 32'(bif.out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    n_checks       = 0;
    n_fails        = 0;
    rst_n          = 1'b0;
    bif.in_valid   = 1'b0;
    bif.op         = 2'b00;
    bif.r2         = 32'd0;
    bif.r3         = 32'd0;
    bif.out_ready  = 1'b0;
    bif32.in_valid = 1'b0;
    bif32.op       = 2'b00;
    bif32.r2       = 32'd0;
    bif32.r3       = 32'd0;
    bif32.out_ready = 1'b0;
    #1;
    check_value("rst.in_ready",  32'(bif.in_ready),  32'd1);
    check_value("rst.out_valid", 32'(bif.out_valid), 32'd0);
    check_value("rst.r1",        bif.r1,             32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // op: 00 SLT, 01 SLTU, 10 SEQ, 11 SNE
    run_op("slt_m5_3",    2'b00, 32'hFFFF_FFFB, 32'd3,         1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sltu_m5_3",   2'b01, 32'hFFFF_FFFB, 32'd3,         1'b0, 1'b1, 1'b0, 1'b0);
    run_op("slt_max_m1",  2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sltu_max_m1", 2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("slt_ovf",     2'b00, 32'h8000_0000, 32'd1,         1'b1, 1'b1, 1'b0, 1'b0);
    run_op("seq_eq",      2'b10, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sne_eq",      2'b11, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("slt_eq",      2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sltu_borrow", 2'b01, 32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sne_borrow",  2'b11, 32'h0000_0100, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held while out_ready stays low.
    start_op(2'b00, 32'd2, 32'd7);
    wait_done(cyc);
    check_value("bp.latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 3; i++) begin
      bif.in_valid = ~bif.in_valid;
      bif.r2       = 32'h1000_0000 + 32'(i);
      step();
      check_value("bp.r1_held",  bif.r1,              32'd1);
      check_value("bp.in_ready", 32'(bif.in_ready),   32'd0);
      check_value("bp.valid",    32'(bif.out_valid),  32'd1);
    end
    bif.in_valid = 1'b0;
    finish_op();
    check_value("bp.released_valid", 32'(bif.out_valid), 32'd0);
    check_value("bp.released_ready", 32'(bif.in_ready),  32'd1);
    start_op(2'b00, 32'hFFFF_FFFB, 32'd3);
    check_value("bp.next_accepted", 32'(bif.in_ready), 32'd0);
    wait_done(cyc);
    check_value("bp.next_latency", 32'(cyc), 32'd4);
    check_value("bp.next_r1",      bif.r1,   32'd1);
    finish_op();

    // Reset two cycles after accept: no partial result, old result cleared.
    start_op(2'b01, 32'd1, 32'd9);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_value("mid_rst.out_valid", 32'(bif.out_valid), 32'd0);
    check_value("mid_rst.r1",        bif.r1,             32'd0);
    check_value("mid_rst.lt_s",      32'(bif.lt_s),      32'd0);
    check_value("mid_rst.lt_u",      32'(bif.lt_u),      32'd0);
    check_value("mid_rst.eq",        32'(bif.eq),        32'd0);
    check_value("mid_rst.in_ready",  32'(bif.in_ready),  32'd1);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst_2_7", 2'b00, 32'd2, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0);

    // Single-chunk instance: result after one cycle.
    check_value("w32.in_ready", 32'(bif32.in_ready), 32'd1);
    bif32.op       = 2'b00;
    bif32.r2       = 32'hFFFF_FFFB;
    bif32.r3       = 32'd3;
    bif32.in_valid = 1'b1;
    step();
    bif32.in_valid = 1'b0;
    cyc = 0;
    while (!bif32.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check_value("w32.latency", 32'(cyc),          32'd1);
    check_value("w32.r1",      bif32.r1,          32'd1);
    check_value("w32.lt_s",    32'(bif32.lt_s),   32'd1);
    check_value("w32.lt_u",    32'(bif32.lt_u),   32'd0);
    bif32.out_ready = 1'b1;
    step();
    bif32.out_ready = 1'b0;
    check_value("w32.out_valid_low", 32'(bif32.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
